// File: rtl/noc_router_vc_arbiter.sv
// Virtual-channel arbiter: several VCs share one link, round-robin with a per-packet wormhole lock.
// Define NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN to arbitrate every flit instead of every packet.
module noc_router_vc_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]                 in_last,
  input  logic [VCHANNELS-1:0]                 in_valid,
  output logic [VCHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic [VCHANNELS-1:0]                 out_valid,
  input  logic [VCHANNELS-1:0]                 out_ready
);

  localparam int PTR_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic [PTR_W-1:0]     lock_reg, lock_next;

  logic [VCHANNELS-1:0]   elig;
  logic [2*VCHANNELS-1:0] elig_dbl;
  logic [VCHANNELS-1:0]   elig_rot;
  logic                   search_hit;
  logic [PTR_W-1:0]       search_vc;
  logic                   sel_active;
  logic [PTR_W-1:0]       sel_vc;
  logic [VCHANNELS-1:0]   owner_oh;
  logic [VCHANNELS-1:0]   fire;
  logic                   xfer;
  logic                   xfer_last;

  // Successor of a VC index; never produces a value of VCHANNELS or above.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    if (v >= PTR_W'(VCHANNELS - 1))
      return '0;
    else
      return v + PTR_W'(1);
  endfunction

  // Maps a position in the rotated request vector back to an absolute VC index.
  function automatic logic [PTR_W-1:0] rot_to_vc(input logic [PTR_W-1:0] base, input int k);
    int g;
    g = int'(base) + k;
    if (g >= VCHANNELS)
      g = g - VCHANNELS;
    return PTR_W'(g);
  endfunction

  // A VC competes only when its downstream can take the flit, so a stalled VC never blocks others.
  assign elig     = in_valid & out_ready;
  assign elig_dbl = {elig, elig};
  assign elig_rot = VCHANNELS'(elig_dbl >> ptr_reg);

  // Lowest rotated position wins, which is the first eligible VC at or after ptr.
  always_comb begin
    search_hit = 1'b0;
    search_vc  = '0;
    for (int k = VCHANNELS - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        search_hit = 1'b1;
        search_vc  = rot_to_vc(ptr_reg, k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      lock_reg  <= lock_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    lock_next  = lock_reg;
    case (state_reg)
      ST_IDLE: begin
        if (xfer) begin
`ifdef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
          ptr_next = wrap_inc(sel_vc);
`else
          if (xfer_last) begin
            ptr_next = wrap_inc(sel_vc);
          end else begin
            state_next = ST_LOCKED;
            lock_next  = sel_vc;
          end
`endif
        end
      end
      ST_LOCKED: begin
        if (xfer && xfer_last) begin
          state_next = ST_IDLE;
          ptr_next   = wrap_inc(lock_reg);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: choose which VC owns the link this cycle.
  always_comb begin
    sel_vc     = search_vc;
    sel_active = search_hit;
    if (VCHANNELS == 1) begin
      sel_vc     = '0;
      sel_active = 1'b1;
    end else if (state_reg == ST_LOCKED) begin
      sel_vc     = lock_reg;
      sel_active = 1'b1;
    end
  end

  // The owner's handshakes pass straight through, so upstream and downstream fire together.
  generate
    for (genvar gi = 0; gi < VCHANNELS; gi++) begin : g_vc
      assign owner_oh[gi]  = sel_active && (sel_vc == PTR_W'(gi)) && !rst;
      assign in_ready[gi]  = owner_oh[gi] & out_ready[gi];
      assign out_valid[gi] = owner_oh[gi] & in_valid[gi];
      assign fire[gi]      = out_valid[gi] & out_ready[gi];
    end
  endgenerate

  assign xfer      = |fire;
  assign xfer_last = |(fire & in_last);

  // Data path is zero whenever nothing is presented on the link.
  always_comb begin
    out_flit = '0;
    out_last = 1'b0;
    for (int k = 0; k < VCHANNELS; k++) begin
      if (out_valid[k]) begin
        out_flit = in_flit[k];
        out_last = in_last[k];
      end
    end
  end

`ifndef SYNTHESIS
  a_in_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_out_valid_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));
  a_ptr_range : assert property (@(posedge clk) disable iff (rst) int'(ptr_reg) < VCHANNELS);
`endif

endmodule

// File: tb/tb_noc_router_vc_arbiter.sv
// Bench for noc_router_vc_arbiter: a 2-VC and a 3-VC instance checked every cycle against a
// packet-level reference model, plus directed cases with literal expectations.
module tb_noc_router_vc_arbiter;

  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][FW-1:0] flit2;
  logic [1:0]         last2, iv2, ir2, ov2, or2;
  logic [FW-1:0]      of2;
  logic               ol2;

  logic [2:0][FW-1:0] flit3;
  logic [2:0]         last3, iv3, ir3, ov3, or3;
  logic [FW-1:0]      of3;
  logic               ol3;

  noc_router_vc_arbiter #(.FLIT_WIDTH(FW), .VCHANNELS(2)) dut2 (
    .clk(clk), .rst(rst), .in_flit(flit2), .in_last(last2), .in_valid(iv2),
    .in_ready(ir2), .out_flit(of2), .out_last(ol2), .out_valid(ov2), .out_ready(or2)
  );

  noc_router_vc_arbiter #(.FLIT_WIDTH(FW), .VCHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_flit(flit3), .in_last(last3), .in_valid(iv3),
    .in_ready(ir3), .out_flit(of3), .out_last(ol3), .out_valid(ov3), .out_ready(or3)
  );

  int checks = 0;
  int errors = 0;

  // Upstream sources, one per VC per instance (instance 0 uses VCs 0..1 only).
  int  src_idx [2][3];
  int  src_len [2][3];
  int  src_pkt [2][3];
  bit  src_on  [2][3];
  bit  rnd_len = 1'b0;

  // Reference model state: owner < 0 means the link is free for arbitration.
  int          m_owner [2];
  int          m_ptr   [2];
  logic [15:0] m_xfer  [2];

  function automatic logic [31:0] flit_val(input int inst, input int vc, input int pkt, input int idx);
    return {8'(inst + 1), 8'(vc), 8'(pkt), 8'(idx)};
  endfunction

  function automatic int nvc(input int inst);
    return (inst == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(input int nv, input logic [15:0] iv, input logic [15:0] orr,
                            input logic [15:0] il, input logic [15:0][31:0] fl,
                            inout int owner, inout int ptr,
                            output logic [15:0] e_ir, output logic [15:0] e_ov,
                            output logic [31:0] e_fl, output logic e_l, output logic [15:0] xf);
    int g;
    int c;
    e_ir = '0; e_ov = '0; e_fl = '0; e_l = 1'b0; xf = '0;
    g = -1;
    if (nv == 1) begin
      g = 0;
      e_ov[0] = iv[0];
      e_ir[0] = orr[0];
    end else if (owner >= 0) begin
      g = owner;
      e_ov[4'(g)] = iv[4'(g)];
      e_ir[4'(g)] = orr[4'(g)];
    end else begin
      for (int k = 0; k < nv; k++) begin
        c = (ptr + k) % nv;
        if (g < 0 && iv[4'(c)] && orr[4'(c)]) g = c;
      end
      if (g >= 0) begin
        e_ov[4'(g)] = 1'b1;
        e_ir[4'(g)] = 1'b1;
      end
    end
    if (e_ov != 0) begin
      e_fl = fl[4'(g)];
      e_l  = il[4'(g)];
    end
    if (g >= 0 && e_ov[4'(g)] && orr[4'(g)]) begin
      xf[4'(g)] = 1'b1;
`ifdef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
      owner = -1;
      ptr   = (g + 1) % nv;
`else
      if (il[4'(g)]) begin
        owner = -1;
        ptr   = (g + 1) % nv;
      end else begin
        owner = g;
      end
`endif
    end
  endtask

  // Compare process: every cycle, both instances, on the falling edge.
  initial begin
    logic [15:0]       e_ir, e_ov, xf;
    logic [31:0]       e_fl;
    logic              e_l;
    logic [15:0][31:0] fl;
    forever begin
      @(negedge clk);
      fl = '0;
      for (int v = 0; v < 2; v++) fl[v] = flit2[v];
      if (rst) begin
        m_owner[0] = -1; m_ptr[0] = 0;
        e_ir = '0; e_ov = '0; e_fl = '0; e_l = 1'b0; xf = '0;
      end else begin
        model_eval(2, 16'(iv2), 16'(or2), 16'(last2), fl, m_owner[0], m_ptr[0], e_ir, e_ov, e_fl, e_l, xf);
      end
      m_xfer[0] = xf;
      chk("dut2_in_ready", 32'(ir2), 32'(e_ir));
      chk("dut2_out_valid", 32'(ov2), 32'(e_ov));
      chk("dut2_out_flit", of2, e_fl);
      chk("dut2_out_last", 32'(ol2), 32'(e_l));
      if (xf != 0) $display("dut2 xfer vc_mask=%b flit=%h last=%0d", xf[1:0], e_fl, e_l);

      fl = '0;
      for (int v = 0; v < 3; v++) fl[v] = flit3[v];
      if (rst) begin
        m_owner[1] = -1; m_ptr[1] = 0;
        e_ir = '0; e_ov = '0; e_fl = '0; e_l = 1'b0; xf = '0;
      end else begin
        model_eval(3, 16'(iv3), 16'(or3), 16'(last3), fl, m_owner[1], m_ptr[1], e_ir, e_ov, e_fl, e_l, xf);
      end
      m_xfer[1] = xf;
      chk("dut3_in_ready", 32'(ir3), 32'(e_ir));
      chk("dut3_out_valid", 32'(ov3), 32'(e_ov));
      chk("dut3_out_flit", of3, e_fl);
      chk("dut3_out_last", 32'(ol3), 32'(e_l));
      if (xf != 0) $display("dut3 xfer vc_mask=%b flit=%h last=%0d", xf[2:0], e_fl, e_l);
    end
  end

  task automatic apply();
    for (int v = 0; v < 2; v++) begin
      flit2[v] = flit_val(0, v, src_pkt[0][v], src_idx[0][v]);
      last2[v] = (src_idx[0][v] == src_len[0][v] - 1);
      iv2[v]   = src_on[0][v];
    end
    for (int v = 0; v < 3; v++) begin
      flit3[v] = flit_val(1, v, src_pkt[1][v], src_idx[1][v]);
      last3[v] = (src_idx[1][v] == src_len[1][v] - 1);
      iv3[v]   = src_on[1][v];
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < nvc(i); v++) begin
        if (m_xfer[i][4'(v)]) begin
          src_idx[i][v]++;
          if (src_idx[i][v] >= src_len[i][v]) begin
            src_idx[i][v] = 0;
            src_pkt[i][v]++;
            if (rnd_len) src_len[i][v] = int'($urandom_range(1, 4));
          end
        end
      end
    end
  endtask

  task automatic src_reset(input int len);
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 3; v++) begin
        src_idx[i][v] = 0;
        src_pkt[i][v] = 0;
        src_len[i][v] = len;
        src_on[i][v]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    advance();
  endtask

  // Leaves the DUTs freshly out of reset, 1 time unit after a rising edge.
  task automatic reset_dut(input int len);
    @(posedge clk);
    #1;
    rst = 1'b1;
    src_reset(len);
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int ev;
    int ei;
    int ep;
    src_reset(3);
    for (int v = 0; v < 3; v++) begin
      src_on[0][v] = 1'b1;
      src_on[1][v] = 1'b1;
    end
    or2 = 2'b11;
    or3 = 3'b111;
    apply();
    #12;
    chk("rst_in_ready2", 32'(ir2), 32'h0);
    chk("rst_out_valid2", 32'(ov2), 32'h0);
    chk("rst_out_flit2", of2, 32'h0);
    chk("rst_out_valid3", 32'(ov3), 32'h0);

    // Two 3-flit packets, link fully ready.
    or3 = 3'b000;
    reset_dut(3);
    or2 = 2'b11;
    src_on[0][0] = 1'b1;
    src_on[0][1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      apply();
      #2;
`ifdef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
      ev = c % 2; ei = c / 2; ep = 0;
`else
      ev = (c < 3) ? 0 : 1; ei = (c < 3) ? c : c - 3; ep = 0;
`endif
      if (c == 6) begin ev = 0; ei = 0; ep = 1; end
      chk($sformatf("pkt2_valid_c%0d", c), 32'(ov2), 32'(1) << ev);
      chk($sformatf("pkt2_flit_c%0d", c), of2, flit_val(0, ev, ep, ei));
    end

    // Downstream of VC0 stalled: VC1 must win in the same cycle.
    reset_dut(1);
    or2 = 2'b10;
    src_on[0][0] = 1'b1;
    src_on[0][1] = 1'b1;
    apply();
    #2;
    chk("stall_in_ready", 32'(ir2), 32'h2);
    chk("stall_out_valid", 32'(ov2), 32'h2);
    chk("stall_out_flit", of2, flit_val(0, 1, 0, 0));
    chk("stall_out_last", 32'(ol2), 32'h1);

    // Bubbles inside a locked VC0 packet while VC1 waits.
    reset_dut(3);
    or2 = 2'b11;
    src_on[0][0] = 1'b1;
    src_on[0][1] = 1'b1;
    apply();
    #2;
    chk("bubble_first", 32'(ov2), 32'h1);
    for (int c = 1; c < 3; c++) begin
      step();
      src_on[0][0] = 1'b0;
      apply();
      #2;
`ifndef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
      chk($sformatf("bubble_valid_c%0d", c), 32'(ov2), 32'h0);
      chk($sformatf("bubble_ready_c%0d", c), 32'(ir2), 32'h1);
      chk($sformatf("bubble_flit_c%0d", c), of2, 32'h0);
`endif
    end
    step();
    src_on[0][0] = 1'b1;
    apply();
    #2;
`ifndef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
    chk("bubble_resume", of2, flit_val(0, 0, 0, 1));
`endif
    step();
    apply();
    #2;
`ifndef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
    chk("bubble_last", 32'(ol2), 32'h1);
`endif
    step();
    apply();
    #2;
`ifndef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
    chk("bubble_then_vc1", 32'(ov2), 32'h2);
`endif

    // Asynchronous reset in the middle of a 4-flit VC1 packet.
    reset_dut(4);
    or2 = 2'b11;
    src_on[0][1] = 1'b1;
    apply();
    #2;
    chk("arst_vc1_first", 32'(ov2), 32'h2);
    step();
    src_on[0][0] = 1'b1;
    apply();
    #1;
`ifdef NOC_ROUTER_VC_ARBITER_INTERLEAVE_EN
    chk("arst_before", 32'(ov2), 32'h1);
`else
    chk("arst_before", of2, flit_val(0, 1, 0, 1));
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(ir2), 32'h0);
    chk("arst_out_valid", 32'(ov2), 32'h0);
    chk("arst_out_flit", of2, 32'h0);
    chk("arst_out_last", 32'(ol2), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_reset(1);
    src_on[0][0] = 1'b1;
    src_on[0][1] = 1'b1;
    apply();
    #2;
    chk("arst_restart_valid", 32'(ov2), 32'h1);
    chk("arst_restart_ready", 32'(ir2), 32'h1);

    // Three VCs, single-flit packets everywhere: rotation and wrap.
    reset_dut(1);
    or2 = 2'b00;
    or3 = 3'b111;
    for (int v = 0; v < 3; v++) src_on[1][v] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      apply();
      #2;
      chk($sformatf("rr3_valid_c%0d", c), 32'(ov3), 32'(1) << (c % 3));
      chk($sformatf("rr3_flit_c%0d", c), of3, flit_val(1, c % 3, c / 3, 0));
    end

    // Randomized traffic with occasional asynchronous resets.
    reset_dut(2);
    rnd_len = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      step();
      rst = 1'b0;
      for (int i = 0; i < 2; i++)
        for (int v = 0; v < 3; v++)
          src_on[i][v] = ($urandom_range(0, 9) < 7);
      or2 = 2'($urandom_range(0, 3));
      or3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        or2 = 2'b11;
        or3 = 3'b111;
      end
      apply();
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst = 1'b1;
      end
    end
    step();
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
